// File: rtl/audio_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | audio_pkg : shared widths, midscale constant, FSM states, stereo word.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package audio_pkg;

  localparam int AUDIO_SAMPLE_WIDTH = 16;
  // Two's complement zero is midscale once converted to offset binary.
  localparam logic [AUDIO_SAMPLE_WIDTH-1:0] AUDIO_MIDSCALE = '0;
  localparam int AUDIO_STATE_W = 2;

  typedef enum logic [AUDIO_STATE_W-1:0] {
    AUD_WAIT = 2'd0,
    AUD_POP  = 2'd1,
    AUD_LOAD = 2'd2
  } aud_state_e;

  typedef struct packed {
    logic [AUDIO_SAMPLE_WIDTH-1:0] left;
    logic [AUDIO_SAMPLE_WIDTH-1:0] right;
  } audio_stereo_t;

endpackage
`default_nettype wire

// File: rtl/audio_sd_dac_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | audio_sd_dac_if : read side of the audio sample FIFO.                    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface audio_sd_dac_if
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH
);

  logic                      fifo_rd;
  logic [2*SAMPLE_WIDTH-1:0] fifo_rd_data;
  logic                      fifo_empty;

  modport master (
    output fifo_rd,
    input  fifo_rd_data,
    input  fifo_empty
  );

  modport slave (
    input  fifo_rd,
    output fifo_rd_data,
    output fifo_empty
  );

endinterface
`default_nettype wire

// File: rtl/audio_sd_mod.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | audio_sd_mod : one channel, offset-binary conversion plus first-order    |
// | delta-sigma accumulator; the carry bit is the registered PDM output.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module audio_sd_mod #(
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] smp,
  output logic                    pdm_out
);

  localparam logic [SAMPLE_WIDTH-1:0] SIGN_BIT = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  logic [SAMPLE_WIDTH-1:0] ob;
  logic [SAMPLE_WIDTH:0]   acc_q;
  logic [SAMPLE_WIDTH:0]   acc_d;

  // Previous carry is dropped each cycle; low bits wrap freely.
  always_comb begin
    ob    = smp ^ SIGN_BIT;
    acc_d = {1'b0, acc_q[SAMPLE_WIDTH-1:0]} + {1'b0, ob};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign pdm_out = acc_q[SAMPLE_WIDTH];

endmodule
`default_nettype wire

// File: rtl/audio_sd_dac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | audio_sd_dac : sample-rate divider, FIFO pop FSM and two delta-sigma     |
// | channels. Option macro AUDIO_DAC_UNDERRUN_MUTE_EN mutes on underrun.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module audio_sd_dac
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
  parameter int SAMPLE_DIV   = 1134
) (
  input  logic           sys_clock,
  input  logic           reset_,
  audio_sd_dac_if.master fifo,
  output logic           underrun,
  output logic           audio_left,
  output logic           audio_right
);

  localparam int               DIV_W    = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [SAMPLE_WIDTH-1:0] MIDSCALE = SAMPLE_WIDTH'(AUDIO_MIDSCALE);

  aud_state_e              state_q;
  aud_state_e              state_d;
  logic [DIV_W-1:0]        div_cnt_q;
  logic [DIV_W-1:0]        div_cnt_d;
  logic                    strobe;
  logic                    load;
  logic                    underrun_q;
  logic                    underrun_d;
  logic [SAMPLE_WIDTH-1:0] smp_l_q;
  logic [SAMPLE_WIDTH-1:0] smp_l_d;
  logic [SAMPLE_WIDTH-1:0] smp_r_q;
  logic [SAMPLE_WIDTH-1:0] smp_r_d;

  assign strobe    = (div_cnt_q == DIV_LAST);
  assign div_cnt_d = strobe ? '0 : div_cnt_q + DIV_W'(1);

  always_ff @(posedge sys_clock) begin
    if (reset_) begin
      state_q <= AUD_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      AUD_WAIT: if (strobe && !fifo.fifo_empty) state_d = AUD_POP;
      AUD_POP:  state_d = AUD_LOAD;
      AUD_LOAD: state_d = AUD_WAIT;
      default:  state_d = AUD_WAIT;
    endcase
  end

  always_comb begin
    fifo.fifo_rd = (state_q == AUD_POP);
    load         = (state_q == AUD_LOAD);
    underrun_d   = (state_q == AUD_WAIT) && strobe && fifo.fifo_empty;
  end

  // Read data arrives the cycle after the pop, which is the LOAD cycle.
  always_comb begin
    smp_l_d = smp_l_q;
    smp_r_d = smp_r_q;
    if (load) begin
      smp_l_d = fifo.fifo_rd_data[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH];
      smp_r_d = fifo.fifo_rd_data[SAMPLE_WIDTH-1:0];
    end
`ifdef AUDIO_DAC_UNDERRUN_MUTE_EN
    else if (underrun_d) begin
      smp_l_d = MIDSCALE;
      smp_r_d = MIDSCALE;
    end
`endif
  end

  always_ff @(posedge sys_clock) begin
    if (reset_) begin
      div_cnt_q  <= '0;
      underrun_q <= 1'b0;
      smp_l_q    <= MIDSCALE;
      smp_r_q    <= MIDSCALE;
    end else begin
      div_cnt_q  <= div_cnt_d;
      underrun_q <= underrun_d;
      smp_l_q    <= smp_l_d;
      smp_r_q    <= smp_r_d;
    end
  end

  assign underrun = underrun_q;

  audio_sd_mod #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH)
  ) u_mod_l (
    .clk     (sys_clock),
    .rst     (reset_),
    .smp     (smp_l_q),
    .pdm_out (audio_left)
  );

  audio_sd_mod #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH)
  ) u_mod_r (
    .clk     (sys_clock),
    .rst     (reset_),
    .smp     (smp_r_q),
    .pdm_out (audio_right)
  );

endmodule
`default_nettype wire

// File: tb/tb_audio_sd_dac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_audio_sd_dac : FIFO model, scoreboarded cycle model, test-plan checks.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_audio_sd_dac;
  import audio_pkg::*;

  localparam int W   = AUDIO_SAMPLE_WIDTH;
  localparam int DIV = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic underrun;
  logic audio_left;
  logic audio_right;

  int n_checks = 0;
  int n_errors = 0;

  audio_sd_dac_if #(.SAMPLE_WIDTH(W)) bus ();

  audio_sd_dac #(
    .SAMPLE_WIDTH(W),
    .SAMPLE_DIV  (DIV)
  ) dut (
    .sys_clock   (clk),
    .reset_      (rst),
    .fifo        (bus),
    .underrun    (underrun),
    .audio_left  (audio_left),
    .audio_right (audio_right)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // FIFO model: registered read data, valid the cycle after fifo_rd.
  audio_stereo_t fifo_mem [0:511];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (bus.fifo_rd) begin
      if (rd_ptr != wr_ptr) begin
        bus.fifo_rd_data <= fifo_mem[rd_ptr];
        rd_ptr <= rd_ptr + 1;
      end else begin
        bus.fifo_rd_data <= '0;
      end
    end
  end

  audio_stereo_t sb [$];

  task automatic push_word(input logic [W-1:0] l, input logic [W-1:0] r);
    fifo_mem[wr_ptr] = {l, r};
    sb.push_back({l, r});
    wr_ptr++;
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Cycle model: strobe N -> rd at N+1, sample live in N+3, output at N+4.
  logic [3:0]    m_div = '0;
  logic          m_rd = 1'b0;
  logic          m_und = 1'b0;
  logic [1:0]    m_ld = '0;
  audio_stereo_t m_word = '0;
  logic [W-1:0]  m_smp_l = '0;
  logic [W-1:0]  m_smp_r = '0;
  logic [W:0]    m_acc_l = '0;
  logic [W:0]    m_acc_r = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_div <= '0; m_rd <= 1'b0; m_und <= 1'b0; m_ld <= '0;
      m_smp_l <= '0; m_smp_r <= '0; m_acc_l <= '0; m_acc_r <= '0;
    end else begin
      m_acc_l <= {1'b0, m_acc_l[W-1:0]} + {1'b0, m_smp_l ^ 16'h8000};
      m_acc_r <= {1'b0, m_acc_r[W-1:0]} + {1'b0, m_smp_r ^ 16'h8000};
      m_rd  <= 1'b0;
      m_und <= 1'b0;
      if (m_ld == 2'd1) begin
        m_smp_l <= m_word.left;
        m_smp_r <= m_word.right;
      end
      if (m_ld != 2'd0) m_ld <= m_ld - 2'd1;
      if (int'(m_div) == DIV - 1) begin
        m_div <= '0;
        if (sb.size() != 0) begin
          m_word <= sb.pop_front();
          m_rd   <= 1'b1;
          m_ld   <= 2'd2;
        end else begin
          m_und <= 1'b1;
`ifdef AUDIO_DAC_UNDERRUN_MUTE_EN
          m_smp_l <= '0;
          m_smp_r <= '0;
`endif
        end
      end else begin
        m_div <= m_div + 4'd1;
      end
    end
  end

  always @(negedge clk) begin
    check("fifo_rd", bus.fifo_rd, m_rd);
    check("underrun", underrun, m_und);
    check("audio_left", audio_left, m_acc_l[W]);
    check("audio_right", audio_right, m_acc_r[W]);
  end

  task automatic wait_sig(input string tag, input bit want_rd, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      seen = want_rd ? bus.fifo_rd : underrun;
    end
    check(tag, seen, 1);
  endtask

  task automatic count_ones(input int n, output int ol, output int orr);
    ol = 0;
    orr = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ol  += int'(audio_left);
      orr += int'(audio_right);
    end
  endtask

  initial begin
    int pops[$];
    int unds[$];
    int ones_l;
    int ones_r;
    int first_rd;

    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_fifo_rd", bus.fifo_rd, 0);
      check("rst_left", audio_left, 0);
      check("rst_right", audio_right, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) push_word(W'($urandom), W'($urandom));

    // Cadence and midscale toggle right after release
    while (cyc < 60) begin
      @(negedge clk);
      if (bus.fifo_rd) pops.push_back(cyc);
      if (underrun) unds.push_back(cyc);
      if (cyc >= 1 && cyc <= 6) check("mid_toggle", audio_left, (cyc % 2 == 0) ? 1 : 0);
    end
    check("pop_count", pops.size(), 4);
    if (pops.size() > 0) check("first_pop_cyc", pops[0], DIV);
    for (int i = 1; i < pops.size(); i++) check("pop_gap", pops[i] - pops[i-1], DIV);
    check("und_count", unds.size(), 3);
    if (unds.size() > 0) check("first_und_cyc", unds[0], 5 * DIV);

    // Density
    for (int i = 0; i < 140; i++) push_word(16'h4000, 16'hC000);
    wait_sig("wait_rd_dens", 1'b1, 20);
    repeat (4) @(negedge clk);
    count_ones(1024, ones_l, ones_r);
    check("dens_left", ones_l, 768);
    check("dens_right", ones_r, 256);
    wait_sig("drain_dens", 1'b0, 400);

    // Extremes
    for (int i = 0; i < 140; i++) push_word(16'h8000, 16'h7FFF);
    wait_sig("wait_rd_ext", 1'b1, 20);
    repeat (4) @(negedge clk);
    count_ones(1024, ones_l, ones_r);
    check("ext_left", ones_l, 0);
    check("ext_right", ones_r, 1024);
    wait_sig("drain_ext", 1'b0, 400);

    // Underrun policy
    push_word(16'h4000, 16'h4000);
    push_word(16'h4000, 16'h4000);
    wait_sig("wait_und_pol", 1'b0, 100);
    repeat (4) @(negedge clk);
    count_ones(256, ones_l, ones_r);
`ifdef AUDIO_DAC_UNDERRUN_MUTE_EN
    check("und_pol_left", ones_l, 128);
    check("und_pol_right", ones_r, 128);
`else
    check("und_pol_left", ones_l, 192);
    check("und_pol_right", ones_r, 192);
`endif

    // Reset asserted during the POP cycle
    for (int i = 0; i < 3; i++) push_word(16'h4000, 16'h4000);
    wait_sig("wait_rd_rst", 1'b1, 20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ones_l = 0;
    first_rd = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cyc >= 1 && cyc <= 6) ones_l += int'(audio_left);
      if (bus.fifo_rd && first_rd < 0) first_rd = cyc;
    end
    check("rst_no_load", ones_l, 3);
    check("rst_next_rd", first_rd, DIV);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
